irq_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the main decoder. It produces the EXL and IV inputs that steer the PC to the handler vector. It latches edges from peripheral sources (timer flag, debounced buttons), applies enable and mask bits, and waits for a safe instruction boundary, meaning not a branch or jump. It then captures the EPC and holds EXL until ERET. Software accesses its STATUS, CAUSE and EPC registers through the MTC0/MFC0 register-select path.

---
 rtl/irq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl
// Interrupt controller feeding the main decoder's EXL/IV steering inputs.
// Rising edges on the source lines latch into CAUSE.PENDING. Each pending bit
// is gated by STATUS.MASK and then by STATUS.IE. A request is taken only on
// an instruction boundary that is not a branch or jump. When it is taken, the
// in-flight PC is captured into EPC and exl is held high until eret.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   irq_src     peripheral request lines, rising-edge sensitive
//   we/addr/wd  MTC0 write path (STATUS, CAUSE, EPC)
//   rd          combinational MFC0 readback, 0 for unmapped addresses
//   pc_current  PC of the instruction in flight
//   int_block   current instruction is a branch/jump; no take this cycle
//   eret        one-cycle handler-return pulse
//   exl         exception level, high while servicing
//   iv          vector select (CAUSE.IV qualified by exl)
//   epc         captured return address
module irq_ctrl #(
  parameter int         NSRC        = 4,
  parameter logic [4:0] ADDR_STATUS = 5'd12,
  parameter logic [4:0] ADDR_CAUSE  = 5'd13,
  parameter logic [4:0] ADDR_EPC    = 5'd14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic [31:0]     pc_current,
  input  logic            int_block,
  input  logic            eret,
  output logic            exl,
  output logic            iv,
  output logic [31:0]     epc
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PEND    = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [NSRC-1:0] prev_src;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic            ie;
  logic            cause_iv;
  logic [2:0]      srcid;
  logic [31:0]     epc_q;

  logic            wr_status;
  logic            wr_cause;
  logic            wr_epc;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clear_bits;
  logic [NSRC-1:0] active;
  logic            req;
  logic [2:0]      winner;
  logic            take;

  assign wr_status  = we && (addr == ADDR_STATUS);
  assign wr_cause   = we && (addr == ADDR_CAUSE);
  assign wr_epc     = we && (addr == ADDR_EPC);
  assign rise       = irq_src & ~prev_src;
  assign clear_bits = wr_cause ? wd[8 +: NSRC] : '0;
  assign active     = pending & mask;
  assign req        = ie & (|active);

  // Lowest-index active source wins; scanning downward lets the lowest
  // index overwrite any higher one.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) winner = 3'(i);
    end
  end

  // PEND exists so a request waits for a boundary that is not a branch or
  // jump. It also drops back to IDLE if software withdraws the request.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) state_next = S_PEND;
      end
      S_PEND: begin
        if (!req) begin
          state_next = S_IDLE;
        end else if (!int_block) begin
          state_next = S_SERVICE;
          take       = 1'b1;
        end
      end
      S_SERVICE: begin
        if (eret) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // A new edge takes priority over a W1C of the same bit in the same cycle,
  // so an edge that lands during the clear is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_src <= '0;
      pending  <= '0;
    end else begin
      prev_src <= irq_src;
      pending  <= (pending & ~clear_bits) | rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie   <= 1'b0;
      mask <= '0;
    end else if (wr_status) begin
      ie   <= wd[0];
      mask <= wd[8 +: NSRC];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_iv <= 1'b0;
      srcid    <= '0;
    end else begin
      if (wr_cause) cause_iv <= wd[23];
      if (take)     srcid    <= winner;
    end
  end

  // The hardware capture must win over a software EPC write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         epc_q <= '0;
    else if (take)   epc_q <= pc_current;
    else if (wr_epc) epc_q <= wd;
  end

  assign exl = (state == S_SERVICE);
  assign iv  = exl & cause_iv;
  assign epc = epc_q;

  always_comb begin
    rd = '0;
    if (addr == ADDR_STATUS) begin
      rd[0]          = ie;
      rd[1]          = exl;
      rd[8 +: NSRC]  = mask;
    end else if (addr == ADDR_CAUSE) begin
      rd[8 +: NSRC]  = pending;
      rd[23]         = cause_iv;
      rd[30:28]      = srcid;
    end else if (addr == ADDR_EPC) begin
      rd = epc_q;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl
// Self-checking bench for irq_ctrl. A flag-based behavioural model of the
// controller is updated every clock edge. Its outputs are compared against the
// DUT shortly after each edge. Directed scenarios with literal expectations
// run first, followed by randomized traffic.
module tb_irq_ctrl;

  localparam int         NSRC = 4;
  localparam logic [4:0] A_ST = 5'd12;
  localparam logic [4:0] A_CA = 5'd13;
  localparam logic [4:0] A_EP = 5'd14;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq_src;
  logic            we;
  logic [4:0]      addr;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic [31:0]     pc_current;
  logic            int_block;
  logic            eret;
  logic            exl;
  logic            iv;
  logic [31:0]     epc;

  int n_compared   = 0;
  int n_mismatched = 0;

  irq_ctrl #(
    .NSRC(NSRC), .ADDR_STATUS(A_ST), .ADDR_CAUSE(A_CA), .ADDR_EPC(A_EP)
  ) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .we(we), .addr(addr), .wd(wd),
    .rd(rd), .pc_current(pc_current), .int_block(int_block), .eret(eret),
    .exl(exl), .iv(iv), .epc(epc)
  );

  always #5 clk = ~clk;

  // Behavioural model: m_busy is "handler running" and m_armed is "a request
  // was seen at the previous edge and is waiting for a safe boundary".
  logic [NSRC-1:0] m_pend, m_mask, m_prev;
  logic            m_ie, m_iv, m_busy, m_armed;
  logic [2:0]      m_srcid;
  logic [31:0]     m_epc;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == A_ST) begin
      v = {16'd0, 4'd0, m_mask, 6'd0, m_busy, m_ie};
    end else if (a == A_CA) begin
      v = (32'(m_srcid) << 28) | (32'(m_iv) << 23) | (32'(m_pend) << 8);
    end else if (a == A_EP) begin
      v = m_epc;
    end
    return v;
  endfunction

  task automatic model_step();
    logic req_now, take_now;
    int   win;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_ie = 0; m_iv = 0;
      m_busy = 0; m_armed = 0; m_srcid = '0; m_epc = '0;
    end else begin
      req_now = m_ie && ((m_pend & m_mask) != 0);
      win = -1;
      for (int i = 0; i < NSRC; i++)
        if (win < 0 && m_pend[i] && m_mask[i]) win = i;
      take_now = m_armed && req_now && !int_block;

      for (int i = 0; i < NSRC; i++) begin
        if (irq_src[i] && !m_prev[i])                   m_pend[i] = 1'b1;
        else if (we && addr == A_CA && wd[8 + i])       m_pend[i] = 1'b0;
      end
      m_prev = irq_src;

      if (we && addr == A_ST) begin
        m_ie   = wd[0];
        m_mask = wd[8 +: NSRC];
      end
      if (we && addr == A_CA) m_iv = wd[23];

      if (take_now) begin
        m_epc   = pc_current;
        m_srcid = 3'(win);
      end else if (we && addr == A_EP) begin
        m_epc = wd;
      end

      if (m_busy) m_armed = 1'b0;
      else        m_armed = req_now && !take_now;

      if (m_busy) begin
        if (eret) m_busy = 1'b0;
      end else if (take_now) begin
        m_busy = 1'b1;
      end
    end
  endtask

  // Compare process: update the model at each edge, then check just after it.
  always begin
    @(posedge clk);
    model_step();
    #1;
    check_output("exl", 32'(exl), 32'(m_busy));
    check_output("iv", 32'(iv), 32'(m_busy & m_iv));
    check_output("epc", epc, m_epc);
    check_output("rd", rd, model_rd(addr));
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic apply_stimulus();
    irq_src = irq_src ^ 4'($urandom_range(0, 5) == 0 ? $urandom_range(0, 15) : 0);
    we = ($urandom_range(0, 5) == 0);
    case ($urandom_range(0, 5))
      0, 1: addr = A_ST;
      2, 3: addr = A_CA;
      4:    addr = A_EP;
      default: addr = 5'($urandom_range(0, 31));
    endcase
    wd = $urandom;
    if (addr == A_ST) wd[0] = ($urandom_range(0, 3) != 0);
    pc_current = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    int_block  = ($urandom_range(0, 2) == 0);
    eret       = m_busy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
    rst        = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; we = 0; addr = A_CA; wd = '0;
    pc_current = '0; int_block = 0; eret = 0;
    repeat (3) cycle();
    check_output("reset_exl", 32'(exl), 32'd0);
    check_output("reset_epc", epc, 32'd0);
    check_output("reset_cause", rd, 32'd0);
    rst = 1'b0;

    // Basic take: edge at k, PEND at k+1, SERVICE at k+2.
    write_reg(A_ST, 32'h0000_0101);
    addr = A_CA; pc_current = 32'h40; irq_src = 4'b0001;
    cycle();
    irq_src = '0;
    check_output("basic_pending", rd, 32'h0000_0100);
    check_output("basic_exl_k", 32'(exl), 32'd0);
    cycle();
    check_output("basic_exl_k1", 32'(exl), 32'd0);
    cycle();
    check_output("basic_exl_k2", 32'(exl), 32'd1);
    check_output("basic_epc", epc, 32'h40);
    check_output("basic_cause", rd, 32'h0000_0100);
    write_reg(A_CA, 32'h0080_0100);
    check_output("basic_iv", 32'(iv), 32'd1);
    check_output("basic_w1c", rd, 32'h0080_0000);
    eret = 1; cycle(); eret = 0;
    check_output("basic_eret_exl", 32'(exl), 32'd0);
    check_output("basic_eret_iv", 32'(iv), 32'd0);
    write_reg(A_CA, 32'h0000_0000);
    cycle();
    check_output("basic_no_reentry", 32'(exl), 32'd0);

    // Branch deferral: blocked for three edges, taken on the fourth.
    irq_src = 4'b0001; int_block = 1; pc_current = 32'h44; cycle();
    irq_src = '0; pc_current = 32'h48; cycle();
    pc_current = 32'h4C; cycle();
    check_output("defer_exl_held", 32'(exl), 32'd0);
    int_block = 0; pc_current = 32'h50; cycle();
    check_output("defer_exl", 32'(exl), 32'd1);
    check_output("defer_epc", epc, 32'h50);
    we = 1; addr = A_CA; wd = 32'h0000_0100; eret = 1; cycle();
    we = 0; eret = 0;
    check_output("defer_eret", 32'(exl), 32'd0);

    // Priority and mask: bit0 pending but masked, bit2 taken.
    write_reg(A_ST, 32'h0000_0E01);
    addr = A_CA; irq_src = 4'b0101; cycle();
    irq_src = '0; cycle(); cycle();
    check_output("prio_exl", 32'(exl), 32'd1);
    check_output("prio_cause", rd, 32'h2000_0500);
    we = 1; wd = 32'h0000_0400; eret = 1; cycle();
    we = 0; eret = 0;
    check_output("prio_eret_exl", 32'(exl), 32'd0);
    check_output("prio_w1c", rd, 32'h2000_0100);
    repeat (3) cycle();
    check_output("prio_no_reentry", 32'(exl), 32'd0);
    // Set and W1C of the same bit in the same cycle: set wins.
    irq_src = 4'b0001; we = 1; wd = 32'h0000_0100; cycle();
    irq_src = '0;
    check_output("set_beats_w1c", rd, 32'h2000_0100);
    cycle();
    we = 0;
    check_output("w1c_after", rd, 32'h2000_0000);

    // Level hold: a held line sets pending once only.
    write_reg(A_ST, 32'h0000_0201);
    addr = A_CA; irq_src = 4'b0010; pc_current = 32'h60;
    repeat (3) cycle();
    check_output("level_exl", 32'(exl), 32'd1);
    check_output("level_cause", rd, 32'h1000_0200);
    we = 1; wd = 32'h0000_0200; eret = 1; cycle();
    we = 0; eret = 0;
    repeat (15) cycle();
    check_output("level_no_reentry", 32'(exl), 32'd0);
    check_output("level_cause_clr", rd, 32'h1000_0000);
    irq_src = '0; cycle();

    // Asynchronous reset in the middle of a service.
    pc_current = 32'h1234; irq_src = 4'b0010; cycle();
    irq_src = '0; cycle(); cycle();
    check_output("rst_pre_exl", 32'(exl), 32'd1);
    #2 rst = 1;
    #1 check_output("rst_exl", 32'(exl), 32'd0);
    check_output("rst_epc", epc, 32'd0);
    addr = A_ST; #1 check_output("rst_status", rd, 32'd0);
    addr = A_CA; #1 check_output("rst_cause", rd, 32'd0);
    cycle(); cycle();
    rst = 0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle();
      apply_stimulus();
    end
    cycle();
    rst = 0; we = 0; eret = 0; irq_src = '0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
